// File: rtl/handshake_pkg.sv
// Shared types and defaults for the four-phase handshake sender.
// Pure declarations: no latency, no flow control.
package handshake_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ_HIGH,
        ACK_WAIT_LOW
    } hs_state_t;

    localparam int HS_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/sync_chain.sv
// Single-bit N-flop synchroniser for an asynchronous level; latency STAGES clocks.
// No backpressure: samples every cycle.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/handshake_sender.sv
// Four-phase req/ack sender: req rises on accept, falls SYNC_STAGES+1 edges after ack.
// Backpressure: in_ready low whenever a transfer is in flight or a stale ack is seen.
module handshake_sender
    import handshake_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = HS_SYNC_STAGES_DEFAULT,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   req_out,
    input  logic                   ack_in,
    output logic                   busy,
    output logic                   xfer_done,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    hs_state_t state;
    logic      ack_sync;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clock (clock),
        .reset (reset),
        .d     (ack_in),
        .q     (ack_sync)
    );

    // A lingering ack in IDLE blocks new words until the receiver releases it.
    assign in_ready = (state == IDLE) && !ack_sync;
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_out    <= 1'b0;
            data_out   <= '0;
            xfer_done  <= 1'b0;
            xfer_count <= '0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_out <= in_data;
                        req_out  <= 1'b1;
                        state    <= REQ_HIGH;
                    end
                end
                REQ_HIGH: begin
                    if (ack_sync) begin
                        req_out <= 1'b0;
                        state   <= ACK_WAIT_LOW;
                    end
                end
                ACK_WAIT_LOW: begin
                    if (!ack_sync) begin
                        xfer_done  <= 1'b1;
                        xfer_count <= xfer_count + COUNT_WIDTH'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_sender.sv
// Bench for handshake_sender: directed scenarios plus randomized traffic against a timing model.
// A second instance with a 4-bit counter exercises wrap-around.
module tb_handshake_sender;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        req_out;
    logic        ack_in;
    logic        busy;
    logic        xfer_done;
    logic [15:0] xfer_count;

    logic [7:0]  in_data_4;
    logic        in_valid_4;
    logic        in_ready_4;
    logic [7:0]  data_out_4;
    logic        req_out_4;
    logic        ack_in_4;
    logic        busy_4;
    logic        xfer_done_4;
    logic [3:0]  xfer_count_4;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_total;
    logic [7:0]  model_data;
    int          tr_done;
    int          tr_acc;

    always #5 clock = ~clock;

    handshake_sender #(.WIDTH(8), .SYNC_STAGES(2), .COUNT_WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .req_out    (req_out),
        .ack_in     (ack_in),
        .busy       (busy),
        .xfer_done  (xfer_done),
        .xfer_count (xfer_count)
    );

    handshake_sender #(.WIDTH(8), .SYNC_STAGES(2), .COUNT_WIDTH(4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data_4),
        .in_valid   (in_valid_4),
        .in_ready   (in_ready_4),
        .data_out   (data_out_4),
        .req_out    (req_out_4),
        .ack_in     (ack_in_4),
        .busy       (busy_4),
        .xfer_done  (xfer_done_4),
        .xfer_count (xfer_count_4)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack_in = 1'b0;
        in_valid_4 = 1'b0; in_data_4 = 8'h00; ack_in_4 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", req_out); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", xfer_done); end
        n_checks++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
        reset = 1'b0;
        tick;
        done_total = 0;
        model_data = 8'h00;
    endtask

    task automatic test_single;
        in_valid = 1'b1; in_data = 8'hA5;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", in_ready); end
        tick;
        in_valid = 1'b0;
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", data_out); end
        n_checks++; if (req_out !== 1'b1) begin n_fail++; $display("FAIL single_req_rise got=%b exp=1", req_out); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        tick;
        ack_in = 1'b1; in_data = 8'h3C;
        tick; tick;
        n_checks++; if (req_out !== 1'b1) begin n_fail++; $display("FAIL req_held_2_edges got=%b exp=1", req_out); end
        tick;
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL req_fall_3rd_edge got=%b exp=0", req_out); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL hold_data_ackhi got=%h exp=a5", data_out); end
        ack_in = 1'b0;
        tick; tick;
        n_checks++; if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL done_early got=%b exp=0", xfer_done); end
        tick;
        n_checks++; if (xfer_done !== 1'b1) begin n_fail++; $display("FAIL done_3rd_edge got=%b exp=1", xfer_done); end
        n_checks++; if (xfer_count !== 16'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", xfer_count); end
        tick;
        n_checks++; if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got=%b exp=0", xfer_done); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL hold_data_idle got=%h exp=a5", data_out); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_stale_ack;
        reset = 1'b1; ack_in = 1'b1; in_valid = 1'b0;
        tick; tick;
        reset = 1'b0;
        tick; tick;
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stale_ready cyc=%0d got=%b exp=0", i, in_ready); end
            tick;
            n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL stale_req cyc=%0d got=%b exp=0", i, req_out); end
        end
        n_checks++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL stale_count got=%0d exp=0", xfer_count); end
        ack_in = 1'b0;
        tick;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stale_ready_1 got=%b exp=0", in_ready); end
        tick;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stale_ready_2 got=%b exp=1", in_ready); end
        tick;
        in_valid = 1'b0;
        n_checks++; if (req_out !== 1'b1 || data_out !== 8'h5A) begin n_fail++; $display("FAIL stale_resume got req=%b data=%h exp req=1 data=5a", req_out, data_out); end
    endtask

    task automatic test_reset_mid;
        #3 reset = 1'b1;
        #1;
        n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL async_req got=%b exp=0", req_out); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL async_data got=%h exp=00", data_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got=%b exp=0", busy); end
        tick;
        reset = 1'b0;
        tick;
        n_checks++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL async_count got=%0d exp=0", xfer_count); end
        done_total = 0;
        model_data = 8'h00;
    endtask

    // Receiver with configurable delays; expectations come from edge counts since each ack edge.
    task automatic run_traffic(input int n, input bit fixed);
        int   acc_n   = 0;
        int   done_n  = 0;
        int   rise    = 100;
        int   fall    = 100;
        int   wait_hi = fixed ? 5 : int'($urandom_range(0, 6));
        int   wait_lo = fixed ? 0 : int'($urandom_range(0, 4));
        logic [1:0] ah = 2'b00;
        bit   idle_m  = 1'b1;
        bit   exp_req = 1'b0;
        bit   exp_done;
        bit   exp_ready;
        bit   acc;
        for (int cyc = 0; cyc < 3000 && done_n < n; cyc++) begin
            if (fixed) begin
                in_valid = (acc_n < n);
                in_data  = 8'(acc_n + 1);
            end else if (!in_valid && acc_n < n && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1; in_data = 8'($urandom);
            end else if (in_valid && $urandom_range(0, 3) == 0) begin
                in_data = 8'($urandom);
            end
            exp_ready = idle_m && !ah[1];
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL tr_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
            acc = in_valid && exp_ready;
            tick;
            ah = {ah[0], ack_in};
            rise++; fall++;
            if (acc) begin
                model_data = in_data; acc_n++; idle_m = 1'b0; exp_req = 1'b1;
                if (!fixed) in_valid = 1'b0;
            end
            if (rise == 3) exp_req = 1'b0;
            exp_done = (fall == 3);
            if (exp_done) begin idle_m = 1'b1; done_n++; done_total++; end
            n_checks++; if (req_out !== exp_req) begin n_fail++; $display("FAIL tr_req cyc=%0d got=%b exp=%b", cyc, req_out, exp_req); end
            n_checks++; if (xfer_done !== exp_done) begin n_fail++; $display("FAIL tr_done cyc=%0d got=%b exp=%b", cyc, xfer_done, exp_done); end
            n_checks++; if (data_out !== model_data) begin n_fail++; $display("FAIL tr_data cyc=%0d got=%h exp=%h", cyc, data_out, model_data); end
            n_checks++; if (busy !== !idle_m) begin n_fail++; $display("FAIL tr_busy cyc=%0d got=%b exp=%b", cyc, busy, !idle_m); end
            n_checks++; if (xfer_count !== 16'(done_total)) begin n_fail++; $display("FAIL tr_count cyc=%0d got=%0d exp=%0d", cyc, xfer_count, 16'(done_total)); end
            if (req_out && !ack_in) begin
                if (wait_hi == 0) begin ack_in = 1'b1; rise = 0; end
                else wait_hi--;
            end else if (!req_out && ack_in) begin
                if (wait_lo == 0) begin
                    ack_in = 1'b0; fall = 0;
                    wait_hi = fixed ? 5 : int'($urandom_range(0, 6));
                    wait_lo = fixed ? 0 : int'($urandom_range(0, 4));
                end else wait_lo--;
            end
        end
        in_valid = 1'b0;
        repeat (3) tick;
        tr_done = done_n;
        tr_acc  = acc_n;
    endtask

    task automatic test_back_to_back;
        run_traffic(4, 1'b1);
        n_checks++; if (tr_acc !== 4) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=4", tr_acc); end
        n_checks++; if (tr_done !== 4) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=4", tr_done); end
        n_checks++; if (xfer_count !== 16'd4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", xfer_count); end
        n_checks++; if (data_out !== 8'h04) begin n_fail++; $display("FAIL b2b_last_data got=%h exp=04", data_out); end
    endtask

    task automatic test_random;
        run_traffic(25, 1'b0);
        n_checks++; if (tr_done !== 25) begin n_fail++; $display("FAIL rand_pulses got=%0d exp=25", tr_done); end
        n_checks++; if (xfer_count !== 16'd29) begin n_fail++; $display("FAIL rand_count got=%0d exp=29", xfer_count); end
    endtask

    task automatic test_wrap;
        int k;
        for (int i = 1; i <= 17; i++) begin
            k = 0;
            while (!in_ready_4 && k < 10) begin tick; k++; end
            n_checks++; if (k >= 10) begin n_fail++; $display("FAIL wrap_ready_timeout xfer=%0d got=0 exp=1", i); end
            in_valid_4 = 1'b1; in_data_4 = 8'(i);
            tick;
            in_valid_4 = 1'b0; ack_in_4 = 1'b1;
            n_checks++; if (data_out_4 !== 8'(i)) begin n_fail++; $display("FAIL wrap_data xfer=%0d got=%h exp=%h", i, data_out_4, 8'(i)); end
            k = 0;
            while (req_out_4 && k < 10) begin tick; k++; end
            ack_in_4 = 1'b0;
            k = 0;
            while (!xfer_done_4 && k < 10) begin tick; k++; end
            n_checks++; if (k >= 10) begin n_fail++; $display("FAIL wrap_done_timeout xfer=%0d got=0 exp=1", i); end
            n_checks++; if (xfer_count_4 !== 4'(i)) begin n_fail++; $display("FAIL wrap_count xfer=%0d got=%0d exp=%0d", i, xfer_count_4, 4'(i)); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_stale_ack;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
